// File: rtl/dpll_lock_detector.sv
`default_nettype none
// ============================================================================
// dpll_lock_detector : per-reference-period phase/correction observer with
//                      lock qualification state machine for the DPLL.
// Revision 1.0
// ============================================================================
module dpll_lock_detector #(
  parameter int CNT_W      = 12,
  parameter int PHASE_TOL  = 2,
  parameter int MAX_CORR   = 4,
  parameter int LOCK_CNT   = 8,
  parameter int UNLOCK_CNT = 2
) (
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic             ref_i,
  input  logic             fb_i,
  input  logic             carry_i,
  input  logic             borrow_i,
  output logic             locked_o,
  output logic             meas_valid_o,
  output logic [CNT_W:0]   phase_err_o,
  output logic [CNT_W-1:0] period_len_o,
  output logic [7:0]       corr_count_o,
  output logic             ref_lost_o
);

  localparam logic [1:0] S_UNLOCKED = 2'd0;
  localparam logic [1:0] S_ACQUIRE  = 2'd1;
  localparam logic [1:0] S_LOCKED   = 2'd2;
  localparam logic [1:0] S_HOLD     = 2'd3;

  localparam logic [CNT_W-1:0] C_CNT_MAX  = '1;
  localparam logic [CNT_W:0]   C_TOL      = (CNT_W+1)'(PHASE_TOL);
  localparam logic [7:0]       C_CORR_MAX = 8'(MAX_CORR);
  localparam logic [7:0]       C_LOCK_N   = 8'(LOCK_CNT);
  localparam logic [7:0]       C_UNLOCK_N = 8'(UNLOCK_CNT);

  logic [2:0]       ref_sync_q, fb_sync_q;
  logic             ref_pulse_q, fb_pulse_q;
  logic [CNT_W-1:0] p_cnt_q, p_cnt_d;
  logic [CNT_W-1:0] fb_pos_q, fb_pos_d;
  logic             fb_seen_q, fb_seen_d;
  logic             fb_multi_q, fb_multi_d;
  logic [7:0]       corr_q, corr_d;
  logic             armed_q, armed_d;
  logic [1:0]       state_q, state_d;
  logic [7:0]       run_q, run_d;
  logic [7:0]       bad_q, bad_d;
  logic             locked_q, locked_d;
  logic             meas_valid_q, meas_valid_d;
  logic [CNT_W:0]   phase_err_q, phase_err_d;
  logic [CNT_W-1:0] period_len_q, period_len_d;
  logic [7:0]       corr_count_q, corr_count_d;
  logic             ref_lost_q, ref_lost_d;

  logic [CNT_W-1:0] w_period_len;
  logic [CNT_W-1:0] w_half;
  logic [CNT_W:0]   w_phase;
  logic [CNT_W:0]   w_phase_abs;
  logic [8:0]       w_corr_sum;
  logic [7:0]       w_corr_sat;
  logic [7:0]       w_corr_new;
  logic             w_good;
  logic [7:0]       w_run_inc;
  logic [7:0]       w_bad_inc;

  // Positions at or past half a period are read as feedback leading the next reference edge.
  always_comb begin
    w_period_len = p_cnt_q + CNT_W'(1);
    w_half       = w_period_len >> 1;
    w_phase      = (fb_pos_q < w_half) ? {1'b0, fb_pos_q}
                                       : ({1'b0, fb_pos_q} - {1'b0, w_period_len});
    w_phase_abs  = w_phase[CNT_W] ? ((CNT_W+1)'(0) - w_phase) : w_phase;
    w_corr_sum   = {1'b0, corr_q} + {8'd0, carry_i} + {8'd0, borrow_i};
    w_corr_sat   = w_corr_sum[8] ? 8'hFF : w_corr_sum[7:0];
    w_corr_new   = {7'd0, carry_i} + {7'd0, borrow_i};
    w_good       = fb_seen_q & ~fb_multi_q & (w_phase_abs <= C_TOL) & (corr_q <= C_CORR_MAX);
    w_run_inc    = run_q + 8'd1;
    w_bad_inc    = bad_q + 8'd1;
  end

  always_comb begin
    p_cnt_d      = p_cnt_q;
    fb_pos_d     = fb_pos_q;
    fb_seen_d    = fb_seen_q;
    fb_multi_d   = fb_multi_q;
    corr_d       = corr_q;
    armed_d      = armed_q;
    state_d      = state_q;
    run_d        = run_q;
    bad_d        = bad_q;
    meas_valid_d = 1'b0;
    phase_err_d  = phase_err_q;
    period_len_d = period_len_q;
    corr_count_d = corr_count_q;
    ref_lost_d   = ref_lost_q;

    if (ref_pulse_q) begin
      // A feedback edge or correction pulse coincident with the reference edge opens the new period.
      p_cnt_d    = '0;
      corr_d     = w_corr_new;
      fb_seen_d  = fb_pulse_q;
      fb_multi_d = 1'b0;
      fb_pos_d   = '0;
      ref_lost_d = 1'b0;
      armed_d    = 1'b1;
      if (armed_q) begin
        meas_valid_d = 1'b1;
        period_len_d = w_period_len;
        phase_err_d  = fb_seen_q ? w_phase : '0;
        corr_count_d = corr_q;
        case (state_q)
          S_UNLOCKED: begin
            if (w_good) begin
              if (C_LOCK_N <= 8'd1) begin
                state_d = S_LOCKED;
              end else begin
                state_d = S_ACQUIRE;
                run_d   = 8'd1;
              end
            end
          end
          S_ACQUIRE: begin
            if (w_good) begin
              run_d = w_run_inc;
              if (w_run_inc >= C_LOCK_N) begin
                state_d = S_LOCKED;
                run_d   = 8'd0;
              end
            end else begin
              state_d = S_UNLOCKED;
              run_d   = 8'd0;
            end
          end
          S_LOCKED: begin
            if (!w_good) begin
              if (C_UNLOCK_N <= 8'd1) begin
                state_d = S_UNLOCKED;
              end else begin
                state_d = S_HOLD;
                bad_d   = 8'd1;
              end
            end
          end
          default: begin
            if (w_good) begin
              state_d = S_LOCKED;
              bad_d   = 8'd0;
            end else begin
              bad_d = w_bad_inc;
              if (w_bad_inc >= C_UNLOCK_N) begin
                state_d = S_UNLOCKED;
                bad_d   = 8'd0;
              end
            end
          end
        endcase
      end
    end else begin
      if (p_cnt_q != C_CNT_MAX) begin
        p_cnt_d = p_cnt_q + CNT_W'(1);
      end
      corr_d = w_corr_sat;
      if (fb_pulse_q) begin
        if (!fb_seen_q) begin
          fb_pos_d  = p_cnt_q + CNT_W'(1);
          fb_seen_d = 1'b1;
        end else begin
          fb_multi_d = 1'b1;
        end
      end
      if (p_cnt_q == C_CNT_MAX) begin
        ref_lost_d = 1'b1;
        armed_d    = 1'b0;
        state_d    = S_UNLOCKED;
        run_d      = 8'd0;
        bad_d      = 8'd0;
      end
    end

    locked_d = (state_d == S_LOCKED) || (state_d == S_HOLD);
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      ref_sync_q   <= '0;
      fb_sync_q    <= '0;
      ref_pulse_q  <= 1'b0;
      fb_pulse_q   <= 1'b0;
      p_cnt_q      <= '0;
      fb_pos_q     <= '0;
      fb_seen_q    <= 1'b0;
      fb_multi_q   <= 1'b0;
      corr_q       <= '0;
      armed_q      <= 1'b0;
      state_q      <= S_UNLOCKED;
      run_q        <= '0;
      bad_q        <= '0;
      locked_q     <= 1'b0;
      meas_valid_q <= 1'b0;
      phase_err_q  <= '0;
      period_len_q <= '0;
      corr_count_q <= '0;
      ref_lost_q   <= 1'b0;
    end else begin
      ref_sync_q   <= {ref_sync_q[1:0], ref_i};
      fb_sync_q    <= {fb_sync_q[1:0], fb_i};
      ref_pulse_q  <= ref_sync_q[1] & ~ref_sync_q[2];
      fb_pulse_q   <= fb_sync_q[1] & ~fb_sync_q[2];
      p_cnt_q      <= p_cnt_d;
      fb_pos_q     <= fb_pos_d;
      fb_seen_q    <= fb_seen_d;
      fb_multi_q   <= fb_multi_d;
      corr_q       <= corr_d;
      armed_q      <= armed_d;
      state_q      <= state_d;
      run_q        <= run_d;
      bad_q        <= bad_d;
      locked_q     <= locked_d;
      meas_valid_q <= meas_valid_d;
      phase_err_q  <= phase_err_d;
      period_len_q <= period_len_d;
      corr_count_q <= corr_count_d;
      ref_lost_q   <= ref_lost_d;
    end
  end

  assign locked_o     = locked_q;
  assign meas_valid_o = meas_valid_q;
  assign phase_err_o  = phase_err_q;
  assign period_len_o = period_len_q;
  assign corr_count_o = corr_count_q;
  assign ref_lost_o   = ref_lost_q;

endmodule
`default_nettype wire

// File: tb/tb_dpll_lock_detector.sv
`default_nettype none
// ============================================================================
// tb_dpll_lock_detector : scoreboard bench for dpll_lock_detector.
// Revision 1.0
// ============================================================================
module tb_dpll_lock_detector;
  localparam int CNT_W  = 12;
  localparam int LOCK_N = 8;
  localparam int UNL_N  = 2;

  logic clk = 1'b0;
  logic reset, ref_in, fb_in, carry, borrow;
  logic             locked, meas_valid, ref_lost;
  logic [CNT_W:0]   phase_err;
  logic [CNT_W-1:0] period_len;
  logic [7:0]       corr_count;

  dpll_lock_detector #(
    .CNT_W(CNT_W), .PHASE_TOL(2), .MAX_CORR(4), .LOCK_CNT(LOCK_N), .UNLOCK_CNT(UNL_N)
  ) dut (
    .clk_i(clk), .reset_i(reset), .ref_i(ref_in), .fb_i(fb_in),
    .carry_i(carry), .borrow_i(borrow),
    .locked_o(locked), .meas_valid_o(meas_valid), .phase_err_o(phase_err),
    .period_len_o(period_len), .corr_count_o(corr_count), .ref_lost_o(ref_lost)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [CNT_W:0]   ph;
    logic [CNT_W-1:0] per;
    logic [7:0]       corr;
    logic             lk;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int last_ref_cyc = 0;
  int m_state, m_run, m_bad;

  always @(posedge clk) cyc <= cyc + 1;

  // Lock qualification reference: 0 unlocked, 1 acquire, 2 locked, 3 hold.
  function automatic logic m_step(input logic good);
    case (m_state)
      0: if (good) begin m_state = 1; m_run = 1; end
      1: if (good) begin
           m_run++;
           if (m_run == LOCK_N) m_state = 2;
         end else begin
           m_state = 0; m_run = 0;
         end
      2: if (!good) begin
           m_bad = 1;
           m_state = (m_bad == UNL_N) ? 0 : 3;
         end
      default: if (good) begin
           m_state = 2; m_bad = 0;
         end else begin
           m_bad++;
           if (m_bad == UNL_N) begin m_state = 0; m_bad = 0; end
         end
    endcase
    return (m_state >= 2);
  endfunction

  always @(posedge clk) begin
    #1;
    if (meas_valid === 1'b1) begin
      if (sb.size() == 0) begin
        checks++; errors++;
        $display("FAIL meas_unexpected: measValid=1 with nothing expected at cycle %0d", cyc);
      end else begin
        mon_e = sb.pop_front();
        checks++;
        if (phase_err !== mon_e.ph) begin
          errors++;
          $display("FAIL phaseErr: got %0d expected %0d", $signed(phase_err), $signed(mon_e.ph));
        end
        checks++;
        if (period_len !== mon_e.per) begin
          errors++;
          $display("FAIL periodLen: got %0d expected %0d", period_len, mon_e.per);
        end
        checks++;
        if (corr_count !== mon_e.corr) begin
          errors++;
          $display("FAIL corrCount: got %0d expected %0d", corr_count, mon_e.corr);
        end
        checks++;
        if (locked !== mon_e.lk) begin
          errors++;
          $display("FAIL locked_at_meas: got %b expected %b", locked, mon_e.lk);
        end
      end
    end
  end

  task automatic model_clear();
    sb.delete();
    m_state = 0; m_run = 0; m_bad = 0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    ref_in = 1'b0; fb_in = 1'b0; carry = 1'b0; borrow = 1'b0;
    repeat (3) @(negedge clk);
    model_clear();
    reset = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  // One reference period of len cycles; fb_off < 0 means no feedback edge.
  task automatic drive_period(input int len, input int fb_off, input bit dbl,
                              input int n_carry, input int n_both, input bit push);
    exp_t e;
    int ph, corr;
    bit good;
    for (int c = 0; c < len; c++) begin
      @(negedge clk);
      if (c == 0) last_ref_cyc = cyc;
      ref_in = (c < len / 2);
      fb_in  = (fb_off >= 0 && c >= fb_off && c < fb_off + 2) ||
               (dbl && fb_off >= 0 && c >= fb_off + 10 && c < fb_off + 12);
      carry  = (c >= 5 && c < 5 + n_carry + n_both);
      borrow = (c >= 5 + n_carry && c < 5 + n_carry + n_both);
    end
    if (push) begin
      if (fb_off < 0)             ph = 0;
      else if (fb_off < len / 2)  ph = fb_off;
      else                        ph = fb_off - len;
      corr = n_carry + 2 * n_both;
      if (corr > 255) corr = 255;
      good = (fb_off >= 0) && !dbl && (ph <= 2) && (ph >= -2) && (corr <= 4);
      e.ph   = (CNT_W+1)'(ph);
      e.per  = CNT_W'(len);
      e.corr = 8'(corr);
      e.lk   = m_step(good);
      sb.push_back(e);
    end
  endtask

  task automatic check_drained(input string name);
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL %s_drain: %0d expected measurements never arrived, required 0", name, sb.size());
    end
  endtask

  task automatic test_reset();
    reset = 1'b0; ref_in = 1'b0; fb_in = 1'b0; carry = 1'b0; borrow = 1'b0;
    #1 reset = 1'b1;
    repeat (2) @(negedge clk);
    checks += 6;
    if (locked !== 1'b0)     begin errors++; $display("FAIL rst_locked: got %b required 0", locked); end
    if (meas_valid !== 1'b0) begin errors++; $display("FAIL rst_measValid: got %b required 0", meas_valid); end
    if (phase_err !== '0)    begin errors++; $display("FAIL rst_phaseErr: got %0d required 0", phase_err); end
    if (period_len !== '0)   begin errors++; $display("FAIL rst_periodLen: got %0d required 0", period_len); end
    if (corr_count !== '0)   begin errors++; $display("FAIL rst_corrCount: got %0d required 0", corr_count); end
    if (ref_lost !== 1'b0)   begin errors++; $display("FAIL rst_refLost: got %b required 0", ref_lost); end
    model_clear();
    reset = 1'b0;
    repeat (20) @(negedge clk);
    checks += 2;
    if (locked !== 1'b0)   begin errors++; $display("FAIL idle_locked: got %b required 0", locked); end
    if (ref_lost !== 1'b0) begin errors++; $display("FAIL idle_refLost: got %b required 0", ref_lost); end
  endtask

  task automatic test_lock_acquire();
    do_reset();
    for (int i = 0; i < 10; i++) begin
      drive_period(40, 1, 0, 0, 0, i < 9);
      if (i == 7) begin
        checks++;
        if (locked !== 1'b0) begin errors++; $display("FAIL lock_7th: got %b required 0", locked); end
      end
      if (i == 8) begin
        checks++;
        if (locked !== 1'b1) begin errors++; $display("FAIL lock_8th: got %b required 1", locked); end
      end
    end
    check_drained("lock");
  endtask

  task automatic test_phase_unlock();
    do_reset();
    repeat (8) drive_period(40, 1, 0, 0, 0, 1);
    drive_period(40, 37, 0, 0, 0, 1);
    drive_period(40, 37, 0, 0, 0, 1);
    checks++;
    if (locked !== 1'b1) begin errors++; $display("FAIL unlock_1st_bad: got %b required 1", locked); end
    drive_period(40, 37, 0, 0, 0, 0);
    checks++;
    if (locked !== 1'b0) begin errors++; $display("FAIL unlock_2nd_bad: got %b required 0", locked); end
    check_drained("unlock");
  endtask

  task automatic test_corr_hold();
    do_reset();
    repeat (8) drive_period(40, 1, 0, 0, 0, 1);
    drive_period(40, 1, 0, 5, 0, 1);
    drive_period(40, 1, 0, 0, 0, 1);
    checks++;
    if (locked !== 1'b1) begin errors++; $display("FAIL hold_locked: got %b required 1", locked); end
    drive_period(40, 1, 0, 0, 0, 0);
    checks++;
    if (locked !== 1'b1) begin errors++; $display("FAIL relock_locked: got %b required 1", locked); end
    check_drained("corr_hold");
  endtask

  task automatic test_corr_sat();
    do_reset();
    drive_period(40, 1, 0, 0, 3, 1);
    drive_period(400, 1, 0, 300, 0, 1);
    drive_period(40, 1, 0, 0, 0, 0);
    check_drained("corr_sat");
  endtask

  task automatic test_same_cycle_multi();
    do_reset();
    drive_period(40, 0, 0, 0, 0, 1);
    drive_period(40, 1, 1, 0, 0, 1);
    drive_period(40, -1, 0, 0, 0, 1);
    drive_period(40, 1, 0, 0, 0, 0);
    check_drained("edges");
  endtask

  task automatic test_reset_mid_acquire();
    do_reset();
    for (int i = 0; i < 5; i++) drive_period(40, 1, 0, 0, 0, i < 4);
    repeat (3) @(negedge clk);
    #2 reset = 1'b1;
    #1;
    checks += 4;
    if (period_len !== '0) begin errors++; $display("FAIL midrst_periodLen: got %0d required 0", period_len); end
    if (phase_err !== '0)  begin errors++; $display("FAIL midrst_phaseErr: got %0d required 0", phase_err); end
    if (locked !== 1'b0)   begin errors++; $display("FAIL midrst_locked: got %b required 0", locked); end
    if (meas_valid !== 1'b0) begin errors++; $display("FAIL midrst_measValid: got %b required 0", meas_valid); end
    check_drained("pre_midrst");
    repeat (2) @(negedge clk);
    model_clear();
    reset = 1'b0;
    repeat (5) @(negedge clk);
    for (int i = 0; i < 9; i++) begin
      drive_period(40, 1, 0, 0, 0, i < 8);
      if (i == 7) begin
        checks++;
        if (locked !== 1'b0) begin errors++; $display("FAIL relock_7th: got %b required 0", locked); end
      end
    end
    checks++;
    if (locked !== 1'b1) begin errors++; $display("FAIL relock_8th: got %b required 1", locked); end
    check_drained("midrst");
  endtask

  task automatic test_ref_lost();
    int elapsed;
    do_reset();
    for (int i = 0; i < 9; i++) drive_period(40, 1, 0, 0, 0, i < 8);
    checks++;
    if (locked !== 1'b1) begin errors++; $display("FAIL lost_prelock: got %b required 1", locked); end
    elapsed = cyc - last_ref_cyc;
    while (ref_lost !== 1'b1 && elapsed < 4300) begin
      @(posedge clk); #1;
      elapsed = cyc - last_ref_cyc;
    end
    checks += 3;
    if (ref_lost !== 1'b1) begin errors++; $display("FAIL refLost_set: got %b required 1 after %0d cycles", ref_lost, elapsed); end
    if (elapsed < 4090 || elapsed > 4110) begin
      errors++; $display("FAIL refLost_time: got %0d cycles required 4090..4110", elapsed);
    end
    if (locked !== 1'b0) begin errors++; $display("FAIL refLost_locked: got %b required 0", locked); end
    m_state = 0; m_run = 0; m_bad = 0;
    drive_period(40, 1, 0, 0, 0, 1);
    checks++;
    if (ref_lost !== 1'b0) begin errors++; $display("FAIL refLost_clear: got %b required 0", ref_lost); end
    drive_period(40, 1, 0, 0, 0, 0);
    check_drained("ref_lost");
  endtask

  initial begin
    test_reset();
    test_lock_acquire();
    test_phase_unlock();
    test_corr_hold();
    test_corr_sat();
    test_same_cycle_multi();
    test_reset_mid_acquire();
    test_ref_lost();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
